// File: rtl/aes_cbc_pkg.sv
// aes_cbc_pkg: shared types and defaults for the CBC decryption sequencer.
// Provides the sequencer state enum, block width and timing defaults.
package aes_cbc_pkg;

  localparam int AES_BLK_W = 128;

  localparam int KEY_WAIT_DEF = 16;
  localparam int DONE_GUARD_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KEXP  = 3'd1,
    ST_READY = 3'd2,
    ST_RUN   = 3'd3,
    ST_OUT   = 3'd4
  } cbc_state_t;

endpackage

// File: rtl/aes_cbc_dec_ctrl.sv
// aes_cbc_dec_ctrl: CBC decrypt sequencer around an AES-128 inverse core.
// Ports: cfg_* key/IV in, in_* ciphertext in, out_* plaintext out, core_* to core.
module aes_cbc_dec_ctrl
  import aes_cbc_pkg::*;
#(
  parameter int KEY_WAIT = KEY_WAIT_DEF,
  parameter int DONE_GUARD = DONE_GUARD_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_vld,
  output logic                 cfg_rdy,
  input  logic [AES_BLK_W-1:0] cfg_key,
  input  logic [AES_BLK_W-1:0] cfg_iv,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [AES_BLK_W-1:0] in_data,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [AES_BLK_W-1:0] out_data,
  output logic                 busy,
  output logic                 core_kld,
  output logic [AES_BLK_W-1:0] core_key,
  output logic                 core_ld,
  output logic [AES_BLK_W-1:0] core_text_in,
  input  logic                 core_done,
  input  logic [AES_BLK_W-1:0] core_text_out
);

  localparam int CMAX =
    (KEY_WAIT > DONE_GUARD) ? KEY_WAIT : DONE_GUARD;
  localparam int CW = $clog2(CMAX + 1);

  localparam logic [CW-1:0] KW_LD = CW'(KEY_WAIT - 1);
  localparam logic [CW-1:0] DG_LD = CW'(DONE_GUARD);

  cbc_state_t state;

  logic [CW-1:0] cnt;

  logic [AES_BLK_W-1:0] key_r;
  logic [AES_BLK_W-1:0] prev_r;
  logic [AES_BLK_W-1:0] cur_r;
  logic [AES_BLK_W-1:0] out_r;

  logic st_ready;

  assign st_ready = (state == ST_READY);

  assign cfg_rdy = (state == ST_IDLE) || st_ready;
  // A re-key offered alongside a block takes priority, so the
  // block must not see a handshake in that cycle.
  assign in_rdy = st_ready && !cfg_vld;
  assign out_vld = (state == ST_OUT);
  assign busy = !((state == ST_IDLE) || st_ready);

  assign out_data = out_r;
  assign core_key = key_r;
  assign core_text_in = cur_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      key_r <= '0;
      prev_r <= '0;
      cur_r <= '0;
      out_r <= '0;
      core_kld <= 1'b0;
      core_ld <= 1'b0;
    end else begin
      core_kld <= 1'b0;
      core_ld <= 1'b0;
      unique case (state)
        ST_IDLE, ST_READY: begin
          if (cfg_vld) begin
            key_r <= cfg_key;
            prev_r <= cfg_iv;
            cnt <= KW_LD;
            core_kld <= 1'b1;
            state <= ST_KEXP;
          end else if (st_ready && in_vld) begin
            cur_r <= in_data;
            cnt <= DG_LD;
            core_ld <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_KEXP: begin
          if (cnt == '0) begin
            state <= ST_READY;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RUN: begin
          // Early done pulses from the core are ignored
          // until the guard counter has drained.
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (core_done) begin
            out_r <= core_text_out ^ prev_r;
            prev_r <= cur_r;
            state <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (out_rdy) begin
            state <= ST_READY;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_cbc_dec_ctrl.sv
// tb_aes_cbc_dec_ctrl: directed bench with a table-lookup model of the core.
// Checks FIPS-197 and SP800-38A CBC vectors, timing and corner cases.
module tb_aes_cbc_dec_ctrl;

  localparam int KW = 16;
  localparam int DG = 2;
  localparam int LAT = 5;
  localparam int TMO = 300;

  localparam logic [127:0] K_FIPS =
    128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_FIPS =
    128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P_FIPS =
    128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_SP =
    128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV_SP =
    128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 =
    128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] P1 =
    128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C2 =
    128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] P2 =
    128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] JUNK =
    128'hdeadbeefdeadbeefdeadbeefdeadbeef;

  logic clk = 1'b0;
  logic rst;
  logic cfg_vld;
  logic cfg_rdy;
  logic [127:0] cfg_key;
  logic [127:0] cfg_iv;
  logic in_vld;
  logic in_rdy;
  logic [127:0] in_data;
  logic out_vld;
  logic out_rdy;
  logic [127:0] out_data;
  logic busy;
  logic core_kld;
  logic [127:0] core_key;
  logic core_ld;
  logic [127:0] core_text_in;
  logic core_done;
  logic [127:0] core_text_out;

  logic spur;
  logic mdl_done;
  logic [127:0] mdl_res;
  logic [127:0] mdl_ct;
  logic [127:0] mdl_key;
  logic [3:0] mdl_cnt;
  logic key_valid;
  int kld_age;
  int ld_viol;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_cbc_dec_ctrl #(
    .KEY_WAIT(KW),
    .DONE_GUARD(DG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cfg_vld(cfg_vld),
    .cfg_rdy(cfg_rdy),
    .cfg_key(cfg_key),
    .cfg_iv(cfg_iv),
    .in_vld(in_vld),
    .in_rdy(in_rdy),
    .in_data(in_data),
    .out_vld(out_vld),
    .out_rdy(out_rdy),
    .out_data(out_data),
    .busy(busy),
    .core_kld(core_kld),
    .core_key(core_key),
    .core_ld(core_ld),
    .core_text_in(core_text_in),
    .core_done(core_done),
    .core_text_out(core_text_out)
  );

  function automatic logic [127:0] aes_inv(
    input logic [127:0] k,
    input logic [127:0] c
  );
    if (k == K_FIPS && c == C_FIPS) return P_FIPS;
    if (k == K_SP && c == C1) return P1 ^ IV_SP;
    if (k == K_SP && c == C2) return P2 ^ C1;
    return ~c;
  endfunction

  assign core_done = mdl_done | spur;
  assign core_text_out = spur ? JUNK : mdl_res;

  always @(posedge clk) begin
    if (rst) begin
      mdl_cnt <= '0;
      mdl_done <= 1'b0;
      mdl_res <= '0;
      key_valid <= 1'b0;
      kld_age <= 0;
    end else begin
      mdl_done <= 1'b0;
      if (core_kld) begin
        key_valid <= 1'b1;
        kld_age <= 0;
      end else if (kld_age < 1000) begin
        kld_age <= kld_age + 1;
      end
      if (core_ld) begin
        if (!key_valid || kld_age < KW) ld_viol <= ld_viol + 1;
        mdl_cnt <= 4'(LAT);
        mdl_ct <= core_text_in;
        mdl_key <= core_key;
      end else if (mdl_cnt != 0) begin
        mdl_cnt <= mdl_cnt - 4'd1;
        if (mdl_cnt == 4'd1) begin
          mdl_done <= 1'b1;
          mdl_res <= aes_inv(mdl_key, mdl_ct);
        end
      end
    end
  end

  task automatic chk(
    input string name,
    input logic [127:0] act,
    input logic [127:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_b(
    input string name,
    input logic act,
    input logic exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    errors++;
    $display("FAIL timeout_%s: got no event expected one", name);
  endtask

  task automatic wait_cfg_rdy();
    int n = 0;
    while (!cfg_rdy && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (!cfg_rdy) tmo("cfg_rdy");
  endtask

  task automatic wait_in_rdy(output int n);
    n = 0;
    while (!in_rdy && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (!in_rdy) tmo("in_rdy");
  endtask

  task automatic do_cfg(
    input logic [127:0] k,
    input logic [127:0] iv
  );
    int n;
    wait_cfg_rdy();
    cfg_vld = 1'b1;
    cfg_key = k;
    cfg_iv = iv;
    @(negedge clk);
    cfg_vld = 1'b0;
    chk_b("kld_pulse", core_kld, 1'b1);
    chk("core_key", core_key, k);
    chk_b("kexp_busy", busy, 1'b1);
    chk_b("kexp_in_rdy", in_rdy, 1'b0);
    @(negedge clk);
    chk_b("kld_one_cycle", core_kld, 1'b0);
    wait_in_rdy(n);
    chk("ready_delay", 128'(n + 2), 128'(KW + 1));
  endtask

  task automatic send_block(input logic [127:0] ct);
    int n;
    wait_in_rdy(n);
    in_vld = 1'b1;
    in_data = ct;
    @(negedge clk);
    in_vld = 1'b0;
    chk_b("ld_pulse", core_ld, 1'b1);
    chk("core_text_in", core_text_in, ct);
    chk_b("run_in_rdy", in_rdy, 1'b0);
  endtask

  task automatic get_out(
    input string name,
    input logic [127:0] exp,
    input int stall
  );
    int n = 0;
    out_rdy = (stall == 0);
    while (!out_vld && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (!out_vld) begin
      tmo(name);
      out_rdy = 1'b1;
      return;
    end
    for (int i = 0; i < stall; i++) begin
      chk({name, "_hold"}, out_data, exp);
      chk_b({name, "_hold_vld"}, out_vld, 1'b1);
      chk_b({name, "_hold_in_rdy"}, in_rdy, 1'b0);
      @(negedge clk);
    end
    out_rdy = 1'b1;
    chk(name, out_data, exp);
    @(negedge clk);
    chk_b({name, "_vld_drop"}, out_vld, 1'b0);
    chk_b({name, "_next_in_rdy"}, in_rdy, 1'b1);
  endtask

  typedef struct {
    logic new_cfg;
    logic [127:0] key;
    logic [127:0] iv;
    logic [127:0] ct;
    logic [127:0] pt;
    int stall;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n;
    vecs[0] = '{1'b1, K_FIPS, '0, C_FIPS, P_FIPS, 0};
    vecs[1] = '{1'b1, K_SP, IV_SP, C1, P1, 0};
    vecs[2] = '{1'b0, K_SP, IV_SP, C2, P2, 0};
    vecs[3] = '{1'b1, K_SP, IV_SP, C1, P1, 20};
    vecs[4] = '{1'b0, K_SP, IV_SP, C2, P2, 0};
    vecs[5] = '{1'b1, K_FIPS, '0, C_FIPS, P_FIPS, 3};

    ld_viol = 0;
    spur = 1'b0;
    rst = 1'b1;
    cfg_vld = 1'b0;
    cfg_key = '0;
    cfg_iv = '0;
    in_vld = 1'b0;
    in_data = '0;
    out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_b("rst_cfg_rdy", cfg_rdy, 1'b1);
    chk_b("rst_in_rdy", in_rdy, 1'b0);
    chk_b("rst_out_vld", out_vld, 1'b0);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_kld", core_kld, 1'b0);
    chk_b("rst_ld", core_ld, 1'b0);
    chk("rst_key", core_key, '0);
    chk("rst_out", out_data, '0);
    rst = 1'b0;
    in_vld = 1'b1;
    repeat (3) @(negedge clk);
    chk_b("idle_no_in_rdy", in_rdy, 1'b0);
    chk_b("idle_no_ld", core_ld, 1'b0);
    in_vld = 1'b0;

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].new_cfg) do_cfg(vecs[i].key, vecs[i].iv);
      send_block(vecs[i].ct);
      get_out($sformatf("row%0d_pt", i), vecs[i].pt, vecs[i].stall);
    end

    do_cfg(K_SP, IV_SP);
    cfg_vld = 1'b1;
    cfg_key = K_FIPS;
    cfg_iv = '0;
    in_vld = 1'b1;
    in_data = C_FIPS;
    #1;
    chk_b("both_in_rdy", in_rdy, 1'b0);
    chk_b("both_cfg_rdy", cfg_rdy, 1'b1);
    @(negedge clk);
    cfg_vld = 1'b0;
    chk_b("both_kld", core_kld, 1'b1);
    chk_b("both_no_ld", core_ld, 1'b0);
    wait_in_rdy(n);
    @(negedge clk);
    in_vld = 1'b0;
    chk_b("both_late_ld", core_ld, 1'b1);
    chk("both_late_ct", core_text_in, C_FIPS);
    get_out("both_pt", P_FIPS, 0);

    send_block(C_FIPS);
    spur = 1'b1;
    repeat (2) @(negedge clk);
    spur = 1'b0;
    chk_b("spur_no_out", out_vld, 1'b0);
    chk_b("spur_busy", busy, 1'b1);
    get_out("spur_pt", P_FIPS ^ C_FIPS, 0);

    do_cfg(K_FIPS, '0);
    send_block(C_FIPS);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_b("mid_rst_out_vld", out_vld, 1'b0);
    chk_b("mid_rst_cfg_rdy", cfg_rdy, 1'b1);
    chk_b("mid_rst_in_rdy", in_rdy, 1'b0);
    chk_b("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_key", core_key, '0);
    chk("mid_rst_ct", core_text_in, '0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk_b("post_rst_quiet", out_vld, 1'b0);
    do_cfg(K_FIPS, '0);
    send_block(C_FIPS);
    get_out("post_rst_pt", P_FIPS, 0);

    repeat (2) @(negedge clk);
    chk("ld_spacing_viol", 128'(ld_viol), '0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
